// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bundle between the multi-cycle sequencer and the
// RV32 datapath / unified memory port.
//   master (controller): takes opcode, zero, mem_ready; drives all enables,
//                        mux selects, debug state, halted/illegal and the
//                        retired-instruction count.
//   slave  (datapath)  : the mirror image.
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_src;
  logic             ir_write;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic [1:0]       wb_sel;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [2:0]       state;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
           wb_sel, alu_src_a, alu_src_b, alu_op, state, halted, illegal,
           instr_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
           wb_sel, alu_src_a, alu_src_b, alu_op, state, halted, illegal,
           instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for the RV32 datapath. One unified
// memory port is shared by instruction fetch and load/store; access states
// stretch while mem_ready is low. Counts retired instructions and halts on
// SYSTEM or unrecognised opcodes.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : multicycle_ctrl_if.master (opcode/zero/mem_ready in; enables,
//          selects, state, halted, illegal, instr_count out)
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  state_t           r_state;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;

  state_t     w_next;
  logic       w_set_illegal;
  logic       w_retire;
  logic       w_pc_write;
  logic       w_pc_src;
  logic       w_ir_write;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_reg_write;
  logic [1:0] w_wb_sel;
  logic [1:0] w_alu_a;
  logic [1:0] w_alu_b;
  logic [1:0] w_alu_op;
  logic       w_halted;

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    w_pc_write    = 1'b0;
    w_pc_src      = 1'b0;
    w_ir_write    = 1'b0;
    w_iord        = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_reg_write   = 1'b0;
    w_wb_sel      = 2'd0;
    w_alu_a       = 2'd0;
    w_alu_b       = 2'd0;
    w_alu_op      = 2'd0;
    w_halted      = 1'b0;

    case (r_state)
      S_FETCH: begin
        // ALU computes PC+4 while the instruction is read.
        w_mem_read = 1'b1;
        w_alu_b    = 2'd1;
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end

      S_DECODE: begin
        // OldPC + imm lands in ALUOut as the branch/jump target.
        w_alu_a = 2'd2;
        w_alu_b = 2'd2;
        case (bus.opcode)
          OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_LUI: w_next = S_EXEC;
          OP_SYS:  w_next = S_HALT;
          default: begin
            w_next        = S_HALT;
            w_set_illegal = 1'b1;
          end
        endcase
      end

      S_EXEC: begin
        w_next = S_FETCH;
        case (bus.opcode)
          OP_R: begin
            w_alu_a = 2'd1; w_alu_b = 2'd0; w_alu_op = 2'b10;
            w_next  = S_WB;
          end
          OP_I: begin
            w_alu_a = 2'd1; w_alu_b = 2'd2; w_alu_op = 2'b10;
            w_next  = S_WB;
          end
          OP_LW, OP_SW: begin
            w_alu_a = 2'd1; w_alu_b = 2'd2; w_alu_op = 2'b00;
            w_next  = S_MEM;
          end
          OP_LUI: begin
            w_alu_a = 2'd3; w_alu_b = 2'd2; w_alu_op = 2'b00;
            w_next  = S_WB;
          end
          OP_BEQ: begin
            w_alu_a    = 2'd1; w_alu_b = 2'd0; w_alu_op = 2'b01;
            w_pc_src   = 1'b1;
            w_pc_write = bus.zero;
          end
          OP_JAL: begin
            // PC still holds PC+4 before this edge: that is the link value.
            w_pc_src    = 1'b1;
            w_pc_write  = 1'b1;
            w_reg_write = 1'b1;
            w_wb_sel    = 2'd2;
          end
          default: ;
        endcase
      end

      S_MEM: begin
        w_iord      = 1'b1;
        w_mem_read  = (bus.opcode == OP_LW);
        w_mem_write = (bus.opcode == OP_SW);
        if (bus.mem_ready) begin
          w_next = (bus.opcode == OP_LW) ? S_WB : S_FETCH;
        end
      end

      S_WB: begin
        w_reg_write = 1'b1;
        w_wb_sel    = (bus.opcode == OP_LW) ? 2'd1 : 2'd0;
        w_next      = S_FETCH;
      end

      S_HALT: begin
        w_halted = 1'b1;
      end

      default: w_next = S_FETCH;
    endcase
  end

  assign w_retire = (w_next == S_FETCH) &&
                    ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_retire)      r_cnt     <= r_cnt + CNT_W'(1);
    end
  end

  // Strobes are gated by reset so an aborted access or write-back cannot
  // commit while rst is low.
  assign bus.pc_write    = w_pc_write  & rst;
  assign bus.ir_write    = w_ir_write  & rst;
  assign bus.mem_read    = w_mem_read  & rst;
  assign bus.mem_write   = w_mem_write & rst;
  assign bus.reg_write   = w_reg_write & rst;
  assign bus.pc_src      = w_pc_src;
  assign bus.iord        = w_iord;
  assign bus.wb_sel      = w_wb_sel;
  assign bus.alu_src_a   = w_alu_a;
  assign bus.alu_src_b   = w_alu_b;
  assign bus.alu_op      = w_alu_op;
  assign bus.state       = r_state;
  assign bus.halted      = w_halted;
  assign bus.illegal     = r_illegal;
  assign bus.instr_count = r_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  localparam int unsigned CNT_W = 32;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_SYS = 7'b1110011;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();
  multicycle_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opc;
    logic        rdy;
    logic        zero;
    logic [19:0] exp;
  } step_t;

  step_t           q[$];
  int              total = 0;
  int              bad   = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  // Packing order: state, pc_write, pc_src, ir_write, iord, mem_read,
  // mem_write, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, halted, illegal
  function automatic logic [19:0] mk(int unsigned st, int unsigned pcw,
      int unsigned pcs, int unsigned irw, int unsigned iord, int unsigned mr,
      int unsigned mw, int unsigned rw, int unsigned wb, int unsigned a,
      int unsigned b, int unsigned op, int unsigned h, int unsigned il);
    return {st[2:0], pcw[0], pcs[0], irw[0], iord[0], mr[0], mw[0], rw[0],
            wb[1:0], a[1:0], b[1:0], op[1:0], h[0], il[0]};
  endfunction

  function automatic logic [19:0] obs();
    return {bus.state, bus.pc_write, bus.pc_src, bus.ir_write, bus.iord,
            bus.mem_read, bus.mem_write, bus.reg_write, bus.wb_sel,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.halted, bus.illegal};
  endfunction

  function automatic logic [19:0] e_fetch(int unsigned rdy);
    return mk(0, rdy, 0, rdy, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
  endfunction

  function automatic logic [19:0] e_dec();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0);
  endfunction

  function automatic logic [19:0] e_rst();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endfunction

  function automatic logic [19:0] e_wb(int unsigned wb);
    return mk(4, 0, 0, 0, 0, 0, 0, 1, wb, 0, 0, 0, 0, 0);
  endfunction

  task automatic push(input logic [6:0] opc, input logic rdy, input logic zero,
                      input logic [19:0] exp);
    step_t s;
    s.opc = opc; s.rdy = rdy; s.zero = zero; s.exp = exp;
    q.push_back(s);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.opcode = OP_R; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    rst = 1'b0;
    #1;
    total++;
    if (obs() !== e_rst()) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=%h", obs(), e_rst());
    end
    total++;
    if (bus.instr_count !== '0) begin
      bad++;
      $display("FAIL reset_count got=%0d want=0", bus.instr_count);
    end
    release_reset();
  endtask

  task automatic test_add();
    step_t s;
    int    cyc = 0;
    push(OP_R, 1, 0, e_fetch(1));
    push(OP_R, 1, 0, e_dec());
    push(OP_R, 1, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0));
    push(OP_R, 1, 0, e_wb(0));
    exp_cnt++;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      bus.opcode = s.opc; bus.mem_ready = s.rdy; bus.zero = s.zero;
      #1;
      total++;
      if (obs() !== s.exp) begin
        bad++;
        $display("FAIL add cyc=%0d got=%h want=%h", cyc, obs(), s.exp);
      end
      cyc++;
    end
    @(posedge clk); #1;
    total++;
    if (bus.instr_count !== exp_cnt) begin
      bad++;
      $display("FAIL add_count got=%0d want=%0d", bus.instr_count, exp_cnt);
    end
  endtask

  task automatic test_lw_wait();
    step_t s;
    int    cyc = 0;
    logic [19:0] e_mem;
    e_mem = mk(3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    push(OP_LW, 0, 0, e_fetch(0));
    push(OP_LW, 0, 0, e_fetch(0));
    push(OP_LW, 1, 0, e_fetch(1));
    push(OP_LW, 1, 0, e_dec());
    push(OP_LW, 1, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    push(OP_LW, 0, 0, e_mem);
    push(OP_LW, 0, 0, e_mem);
    push(OP_LW, 1, 0, e_mem);
    push(OP_LW, 1, 0, e_wb(1));
    exp_cnt++;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      bus.opcode = s.opc; bus.mem_ready = s.rdy; bus.zero = s.zero;
      #1;
      total++;
      if (obs() !== s.exp) begin
        bad++;
        $display("FAIL lw_wait cyc=%0d got=%h want=%h", cyc, obs(), s.exp);
      end
      cyc++;
    end
    @(posedge clk); #1;
    total++;
    if (bus.instr_count !== exp_cnt || bus.state !== 3'd0) begin
      bad++;
      $display("FAIL lw_end count=%0d state=%0d want count=%0d state=0",
               bus.instr_count, bus.state, exp_cnt);
    end
  endtask

  task automatic test_branch_jump();
    step_t s;
    int    cyc = 0;
    // BEQ taken, BEQ not taken (zero=1 in FETCH/DECODE proves it is ignored there), JAL
    push(OP_BEQ, 1, 0, e_fetch(1));
    push(OP_BEQ, 1, 0, e_dec());
    push(OP_BEQ, 1, 1, mk(2, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    push(OP_BEQ, 1, 1, e_fetch(1));
    push(OP_BEQ, 1, 1, e_dec());
    push(OP_BEQ, 1, 0, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    push(OP_JAL, 1, 0, e_fetch(1));
    push(OP_JAL, 1, 0, e_dec());
    push(OP_JAL, 1, 0, mk(2, 1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
    push(OP_JAL, 1, 0, e_fetch(1));
    exp_cnt += 3;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      bus.opcode = s.opc; bus.mem_ready = s.rdy; bus.zero = s.zero;
      #1;
      total++;
      if (obs() !== s.exp) begin
        bad++;
        $display("FAIL branch_jump cyc=%0d got=%h want=%h", cyc, obs(), s.exp);
      end
      cyc++;
    end
    total++;
    if (bus.instr_count !== exp_cnt) begin
      bad++;
      $display("FAIL branch_jump_count got=%0d want=%0d", bus.instr_count, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    step_t s;
    int    cyc = 0;
    // Continues from the FETCH left by the previous task (its FETCH cycle was already checked).
    push(OP_I, 1, 0, e_dec());
    push(OP_I, 1, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0));
    push(OP_I, 1, 0, e_wb(0));
    push(OP_LUI, 1, 0, e_fetch(1));
    push(OP_LUI, 1, 0, e_dec());
    push(OP_LUI, 1, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2, 0, 0, 0));
    push(OP_LUI, 1, 0, e_wb(0));
    push(OP_SW, 1, 0, e_fetch(1));
    push(OP_SW, 1, 0, e_dec());
    push(OP_SW, 1, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    push(OP_SW, 1, 0, mk(3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    exp_cnt += 3;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      bus.opcode = s.opc; bus.mem_ready = s.rdy; bus.zero = s.zero;
      #1;
      total++;
      if (obs() !== s.exp) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got=%h want=%h", cyc, obs(), s.exp);
      end
      cyc++;
    end
    @(posedge clk); #1;
    total++;
    if (bus.instr_count !== exp_cnt) begin
      bad++;
      $display("FAIL back_to_back_count got=%0d want=%0d", bus.instr_count, exp_cnt);
    end
  endtask

  task automatic test_mid_reset();
    step_t s;
    int    cyc = 0;
    push(OP_SW, 1, 0, e_fetch(1));
    push(OP_SW, 1, 0, e_dec());
    push(OP_SW, 1, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    push(OP_SW, 0, 0, mk(3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    push(OP_SW, 0, 0, mk(3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      bus.opcode = s.opc; bus.mem_ready = s.rdy; bus.zero = s.zero;
      #1;
      total++;
      if (obs() !== s.exp) begin
        bad++;
        $display("FAIL mid_reset cyc=%0d got=%h want=%h", cyc, obs(), s.exp);
      end
      cyc++;
    end
    #2 rst = 1'b0;
    exp_cnt = '0;
    #1;
    total++;
    if (obs() !== e_rst() || bus.instr_count !== exp_cnt) begin
      bad++;
      $display("FAIL mid_reset_abort got=%h count=%0d want=%h count=0",
               obs(), bus.instr_count, e_rst());
    end
  endtask

  task automatic test_halt();
    step_t s;
    int    cyc = 0;
    logic [19:0] e_h0;
    logic [19:0] e_h1;
    e_h0 = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    e_h1 = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    release_reset();
    push(OP_R, 1, 0, e_fetch(1));
    push(OP_R, 1, 0, e_dec());
    push(OP_R, 1, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0));
    push(OP_R, 1, 0, e_wb(0));
    push(OP_SYS, 1, 0, e_fetch(1));
    push(OP_SYS, 1, 0, e_dec());
    push(OP_SYS, 1, 0, e_h0);
    push(OP_R,   1, 1, e_h0);
    push(OP_R,   0, 0, e_h0);
    exp_cnt = 1;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      bus.opcode = s.opc; bus.mem_ready = s.rdy; bus.zero = s.zero;
      #1;
      total++;
      if (obs() !== s.exp) begin
        bad++;
        $display("FAIL halt_sys cyc=%0d got=%h want=%h", cyc, obs(), s.exp);
      end
      cyc++;
    end
    total++;
    if (bus.instr_count !== exp_cnt) begin
      bad++;
      $display("FAIL halt_sys_count got=%0d want=%0d", bus.instr_count, exp_cnt);
    end

    #2 rst = 1'b0;
    exp_cnt = '0;
    #1;
    total++;
    if (obs() !== e_rst() || bus.instr_count !== exp_cnt) begin
      bad++;
      $display("FAIL halt_reset1 got=%h count=%0d want=%h count=0",
               obs(), bus.instr_count, e_rst());
    end

    release_reset();
    cyc = 0;
    push(OP_R, 1, 0, e_fetch(1));
    push(OP_R, 1, 0, e_dec());
    push(OP_R, 1, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0));
    push(OP_R, 1, 0, e_wb(0));
    push(OP_BAD, 1, 0, e_fetch(1));
    push(OP_BAD, 1, 0, e_dec());
    push(OP_BAD, 1, 0, e_h1);
    push(OP_R,   1, 0, e_h1);
    push(OP_SYS, 1, 0, e_h1);
    exp_cnt = 1;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      bus.opcode = s.opc; bus.mem_ready = s.rdy; bus.zero = s.zero;
      #1;
      total++;
      if (obs() !== s.exp) begin
        bad++;
        $display("FAIL halt_illegal cyc=%0d got=%h want=%h", cyc, obs(), s.exp);
      end
      cyc++;
    end
    total++;
    if (bus.instr_count !== exp_cnt) begin
      bad++;
      $display("FAIL halt_illegal_count got=%0d want=%0d", bus.instr_count, exp_cnt);
    end

    #2 rst = 1'b0;
    #1;
    total++;
    if (obs() !== e_rst() || bus.instr_count !== '0) begin
      bad++;
      $display("FAIL halt_reset2 got=%h count=%0d want=%h count=0",
               obs(), bus.instr_count, e_rst());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch_jump();
    test_back_to_back();
    test_mid_reset();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
